// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: access size codes, LSU FSM states and
// the stall/flush flag encodings also consumed by the pipeline control block.
package pipe_ctrl_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } lsu_state_e;

    // Flag vectors are {pc, if_id, id_ex}.
    localparam logic [2:0] STALL_FRONT = 3'b110;
    localparam logic [2:0] FLUSH_IDEX  = 3'b001;
    localparam logic [2:0] FLAG_NONE   = 3'b000;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] off);
        logic mis;
        case (size)
            SZ_B:    mis = 1'b0;
            SZ_H:    mis = off[0];
            SZ_W:    mis = |off[1:0];
            default: mis = |off;
        endcase
        return mis;
    endfunction

    function automatic logic [7:0] size_mask(input logic [1:0] size);
        logic [7:0] mask;
        case (size)
            SZ_B:    mask = 8'h01;
            SZ_H:    mask = 8'h03;
            SZ_W:    mask = 8'h0F;
            default: mask = 8'hFF;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: store strobes/data shifted into their lanes,
// load data shifted down, truncated to the access size and extended to 64 bits.
module lsu_align import pipe_ctrl_pkg::*; (
    input  logic [2:0]  off_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [63:0] wdata_i,
    input  logic [63:0] rdata_i,
    output logic [7:0]  wmask_o,
    output logic [63:0] wdata_o,
    output logic [63:0] rdata_o
);

    logic [5:0]  bit_off;
    logic [63:0] rdata_sh;
    logic        sign;

    assign bit_off  = {off_i, 3'b000};
    assign wmask_o  = size_mask(size_i) << off_i;
    assign wdata_o  = wdata_i << bit_off;
    assign rdata_sh = rdata_i >> bit_off;

    // Doublewords fill the register, so the unsigned flag has nothing to do there.
    always_comb begin
        sign    = 1'b0;
        rdata_o = rdata_sh;
        case (size_i)
            SZ_B: begin
                sign    = ~unsigned_i & rdata_sh[7];
                rdata_o = {{56{sign}}, rdata_sh[7:0]};
            end
            SZ_H: begin
                sign    = ~unsigned_i & rdata_sh[15];
                rdata_o = {{48{sign}}, rdata_sh[15:0]};
            end
            SZ_W: begin
                sign    = ~unsigned_i & rdata_sh[31];
                rdata_o = {{32{sign}}, rdata_sh[31:0]};
            end
            default: rdata_o = rdata_sh;
        endcase
    end

endmodule

// File: rtl/lsu_mem_stall.sv
// MEM-stage load/store unit: issues one captured access on a valid/ready bus,
// waits for the response and stalls the front of the pipeline while busy.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | no access outstanding; accepts an aligned mem_req_i
// REQ     | req_valid_o high, request fields held until req_ready_i
// WAIT    | request accepted, waiting for rsp_valid_i or timeout
module lsu_mem_stall import pipe_ctrl_pkg::*; #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    input  logic [1:0]        mem_size_i,
    input  logic              mem_unsigned_i,
    input  logic [4:0]        rd_addr_i,
    output logic              req_valid_o,
    input  logic              req_ready_i,
    output logic              req_we_o,
    output logic [ADDR_W-1:0] req_addr_o,
    output logic [DATA_W-1:0] req_wdata_o,
    output logic [7:0]        req_wmask_o,
    input  logic              rsp_valid_i,
    input  logic [DATA_W-1:0] rsp_rdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic [4:0]        rd_addr_o,
    output logic              rd_we_o,
    output logic              misalign_o,
    output logic              bus_err_o,
    output logic [2:0]        stall_flag_mem_o,
    output logic [2:0]        flush_flag_mem_o
);

    lsu_state_e        state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [4:0]        rd_q, rd_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [4:0]        rd_addr_q, rd_addr_d;
    logic              rd_we_q, rd_we_d;
    logic              misalign_q, misalign_d;
    logic              bus_err_q, bus_err_d;

    logic              req_aligned;
    logic              accept;
    logic              busy;
    logic [7:0]        wmask;
    logic [DATA_W-1:0] wdata_sh;
    logic [DATA_W-1:0] load_ext;

    assign req_aligned = ~is_misaligned(mem_size_i, mem_addr_i[2:0]);
    assign accept      = rst && (state_q == ST_IDLE) && mem_req_i && req_aligned;
    assign busy        = (state_q != ST_IDLE) || accept;

    lsu_align u_align (
        .off_i      (addr_q[2:0]),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .wdata_i    (wdata_q),
        .rdata_i    (rsp_rdata_i),
        .wmask_o    (wmask),
        .wdata_o    (wdata_sh),
        .rdata_o    (load_ext)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        size_d     = size_q;
        uns_d      = uns_q;
        rd_d       = rd_q;
        rdata_d    = rdata_q;
        rd_addr_d  = rd_addr_q;
        rd_we_d    = 1'b0;
        misalign_d = 1'b0;
        bus_err_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_req_i) begin
                    if (req_aligned) begin
                        we_d    = mem_we_i;
                        addr_d  = mem_addr_i;
                        wdata_d = mem_wdata_i;
                        size_d  = mem_size_i;
                        uns_d   = mem_unsigned_i;
                        rd_d    = rd_addr_i;
                        state_d = ST_REQ;
                    end else begin
                        misalign_d = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                if (req_ready_i) begin
                    state_d = ST_WAIT;
                    cnt_d   = 8'd0;
                end
            end
            ST_WAIT: begin
                if (rsp_valid_i) begin
                    state_d = ST_IDLE;
                    if (!we_q) begin
                        rdata_d   = load_ext;
                        rd_addr_d = rd_q;
                        rd_we_d   = 1'b1;
                    end
                end else begin
                    // The cycle that would bring the count to TIMEOUT ends the access.
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == 8'(TIMEOUT - 1)) begin
                        state_d   = ST_IDLE;
                        bus_err_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 8'd0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            size_q     <= SZ_B;
            uns_q      <= 1'b0;
            rd_q       <= 5'd0;
            rdata_q    <= '0;
            rd_addr_q  <= 5'd0;
            rd_we_q    <= 1'b0;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            rd_q       <= rd_d;
            rdata_q    <= rdata_d;
            rd_addr_q  <= rd_addr_d;
            rd_we_q    <= rd_we_d;
            misalign_q <= misalign_d;
            bus_err_q  <= bus_err_d;
        end
    end

    assign req_valid_o      = (state_q == ST_REQ);
    assign req_we_o         = req_valid_o & we_q;
    assign req_addr_o       = req_valid_o ? {addr_q[ADDR_W-1:3], 3'b000} : '0;
    assign req_wmask_o      = req_we_o ? wmask : 8'h00;
    assign req_wdata_o      = req_we_o ? wdata_sh : '0;
    assign rdata_o          = rdata_q;
    assign rd_addr_o        = rd_addr_q;
    assign rd_we_o          = rd_we_q;
    assign misalign_o       = misalign_q;
    assign bus_err_o        = bus_err_q;
    assign stall_flag_mem_o = busy ? STALL_FRONT : FLAG_NONE;
    assign flush_flag_mem_o = busy ? FLUSH_IDEX : FLAG_NONE;

    a_rsp_at_handshake: assert property (@(posedge clk) disable iff (!rst)
        !(req_valid_o && req_ready_i && rsp_valid_i));

    a_req_while_busy: assert property (@(posedge clk) disable iff (!rst)
        !((state_q != ST_IDLE) && mem_req_i));

endmodule

// File: doc/lsu_mem_stall.md
Name: lsu_mem_stall

Overview:
- MEM-stage load/store unit.
- Captures one memory op from the EX/MEM boundary and issues it on a valid/ready data bus.
- Waits for the response, then aligns and extends load data for writeback.
- While an access is outstanding it is the producer of stall_flag_mem/flush_flag_mem for the pipeline control block:
  - holds PC and IF/ID;
  - bubbles ID/EX.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, bus data width (fixed 64; 8-byte lanes).
- TIMEOUT, 255, max cycles in WAIT before abort (8-bit counter).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- mem_req_i  in  1  one-cycle pulse: valid load/store this cycle.
- mem_we_i  in  1  1=store, 0=load.
- mem_addr_i  in  64  byte address.
- mem_wdata_i  in  64  store data, LSB-justified.
- mem_size_i  in  2  0=B, 1=H, 2=W, 3=D.
- mem_unsigned_i  in  1  zero-extend load.
- rd_addr_i  in  5  load destination.
- req_valid_o  out  1  bus request valid.
- req_ready_i  in  1  bus accepts request.
- req_we_o  out  1  store request.
- req_addr_o  out  64  address, aligned down to 8 bytes.
- req_wdata_o  out  64  lane-shifted store data.
- req_wmask_o  out  8  byte strobes.
- rsp_valid_i  in  1  response/write-ack, one cycle.
- rsp_rdata_i  in  64  response data.
- rdata_o  out  64  extended load result.
- rd_addr_o  out  5  writeback register.
- rd_we_o  out  1  one-cycle writeback strobe, loads only.
- misalign_o  out  1  one-cycle misaligned-access pulse.
- bus_err_o  out  1  one-cycle timeout pulse.
- stall_flag_mem_o  out  3  {pc, if_id, id_ex} stall.
- flush_flag_mem_o  out  3  {pc, if_id, id_ex} flush.

Behaviour:
- Reset (rst=0, async): state IDLE, counter 0; all outputs 0.
- FSM states: IDLE, REQ, WAIT.
- IDLE, mem_req_i=1, aligned:
  - capture we/addr/wdata/size/unsigned/rd into regs;
  - next state REQ.
- IDLE, mem_req_i=1, misaligned:
  - misalignment: addr[0] set for H, addr[1:0]≠0 for W, addr[2:0]≠0 for D;
  - no capture, no bus request, no stall;
  - misalign_o=1 next cycle.
- REQ:
  - req_valid_o=1 with all req_* fields stable until req_ready_i;
  - on handshake go to WAIT, counter cleared.
- WAIT:
  - on rsp_valid_i: go to IDLE; for loads register rdata_o, drive rd_addr_o and rd_we_o=1 for exactly that next cycle; stores give no rd_we_o.
  - otherwise counter++; when counter reaches TIMEOUT, go to IDLE and pulse bus_err_o; rd_we_o stays 0.
- A response is never sampled in REQ; rsp arriving in the same cycle as the handshake is a protocol violation (assertion).
- Stall/flush generation (combinational), busy = (state≠IDLE) or (IDLE and mem_req_i and aligned):
  - busy: stall_flag_mem_o=3'b110, flush_flag_mem_o=3'b001;
  - not busy: both 3'b000.
- Minimum latency, ready and rsp immediate:
  - request cycle 0; REQ cycle 1; WAIT cycle 2 (rsp); result cycle 3;
  - stall asserted cycles 0-2.
- Store lanes, off = addr[2:0]:
  - wmask = {1,3,F,FF}[size] << off;
  - wdata = mem_wdata_i << (8·off).
- Load extract:
  - rsp_rdata_i >> (8·off), truncated to size;
  - sign- or zero-extended to 64 per mem_unsigned_i; D ignores the unsigned flag.
- mem_req_i while state≠IDLE is ignored (assertion flags it).
- rsp_valid_i in IDLE is ignored.
- Reset mid-access aborts silently; any later stray rsp is ignored.

Decomposition:
- Shared package (pipe_ctrl_pkg):
  - size encodings SZ_B/H/W/D;
  - FSM state typedef;
  - flag constants STALL_FRONT=3'b110, FLUSH_IDEX=3'b001, FLAG_NONE=3'b000 (also consumed by the control block).
- One natural sub-module: lsu_align, a purely combinational block for wmask/wdata shifting and load extraction/extension. The top level holds the FSM, counter and flag logic.

Test Plan:
- Load W unsigned=0, addr 0x8000_0004, ready and rsp immediate, rdata 0x8765_4321_0000_0000 -> rdata_o=0xFFFF_FFFF_8765_4321, rd_we_o=1 at cycle 3, stall 3'b110 / flush 3'b001 cycles 0-2.
- Store B, addr 0x...0003, wdata 0xAB, ready delayed 4 cycles -> req_wmask_o=0x08, req_wdata_o=0xAB00_0000, req fields stable all 5 REQ cycles, no rd_we_o.
- Load H, addr 0x...0001 -> misalign_o=1 next cycle, req_valid_o never high, stall flags stay 0.
- WAIT with no rsp for 255 cycles -> bus_err_o pulse, return to IDLE, flags 0; rsp_valid_i injected later is ignored.
- Load D, rst dropped during WAIT -> all outputs 0 immediately, IDLE; next load completes normally.
- Back-to-back: new mem_req_i in the result cycle -> accepted, stall continuous; rd_we_o pulses once per load.
